// File: rtl/iiitb_tlc_monitor.sv
`timescale 1ns/1ps
// Passive traffic-light monitor: decodes the highway/farm lamp buses into controller
// phases, checks the phase order and minimum dwell, and latches a sticky fault with cause.
module iiitb_tlc_monitor #(
    parameter int unsigned MIN_GREEN  = 1,
    parameter int unsigned MIN_YELLOW = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       light_highway,
    input  logic [2:0]       light_farm,
    input  logic             clear,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] dwell,
    output logic [7:0]       cycle_count,
    output logic             fault,
    output logic [2:0]       fault_code
);

    typedef enum logic [1:0] {ST_SYNC, ST_TRACK, ST_FAULT} state_e;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_INVALID  = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_ILLEGAL  = 3'd3;
    localparam logic [2:0] FC_SHORT    = 3'd4;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);

    state_e           state_q, state_d;
    logic [2:0]       s_hw_q, s_hw_d;
    logic [2:0]       s_fm_q, s_fm_d;
    logic             smp_vld_q, smp_vld_d;
    logic [1:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [7:0]       cycle_count_q, cycle_count_d;
    logic             fault_q, fault_d;
    logic [2:0]       fault_code_q, fault_code_d;

    logic       dec_ok;
    logic [1:0] dec_phase;
    logic       dec_conflict;
    logic       dec_invalid;
    logic [1:0] next_phase;
    logic       dwell_met;
    logic [2:0] trk_code;

    // Decode works only on the registered lamp samples.
    always_comb begin
        dec_ok    = 1'b1;
        dec_phase = 2'd0;
        case ({s_hw_q, s_fm_q})
            6'b001_100: dec_phase = 2'd0;
            6'b010_100: dec_phase = 2'd1;
            6'b100_001: dec_phase = 2'd2;
            6'b100_010: dec_phase = 2'd3;
            default:    dec_ok    = 1'b0;
        endcase
    end

    assign dec_conflict = (s_hw_q != LAMP_RED) && (s_fm_q != LAMP_RED);
    assign dec_invalid  = !dec_ok && !dec_conflict;
    assign next_phase   = phase_q + 2'd1;
    assign dwell_met    = phase_q[0] ? (dwell_q >= MIN_Y) : (dwell_q >= MIN_G);

    always_comb begin
        trk_code = FC_NONE;
        if (dec_conflict) begin
            trk_code = FC_CONFLICT;
        end else if (dec_invalid) begin
            trk_code = FC_INVALID;
        end else if (dec_phase != phase_q && dec_phase != next_phase) begin
            trk_code = FC_ILLEGAL;
        end else if (dec_phase == next_phase && !dwell_met) begin
            trk_code = FC_SHORT;
        end
    end

    always_comb begin
        s_hw_d        = light_highway;
        s_fm_d        = light_farm;
        smp_vld_d     = 1'b1;
        state_d       = state_q;
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        dwell_d       = dwell_q;
        cycle_count_d = cycle_count_q;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;

        if (clear) begin
            state_d       = ST_SYNC;
            phase_d       = 2'd0;
            phase_valid_d = 1'b0;
            dwell_d       = '0;
            cycle_count_d = 8'd0;
            fault_d       = 1'b0;
            fault_code_d  = FC_NONE;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    // The sample register holds nothing meaningful until one edge after reset.
                    if (smp_vld_q) begin
                        if (dec_ok) begin
                            state_d       = ST_TRACK;
                            phase_d       = dec_phase;
                            phase_valid_d = 1'b1;
                            dwell_d       = DWELL_ONE;
                        end else begin
                            state_d      = ST_FAULT;
                            fault_d      = 1'b1;
                            fault_code_d = dec_conflict ? FC_CONFLICT : FC_INVALID;
                        end
                    end
                end
                ST_TRACK: begin
                    if (trk_code != FC_NONE) begin
                        state_d       = ST_FAULT;
                        phase_valid_d = 1'b0;
                        fault_d       = 1'b1;
                        fault_code_d  = trk_code;
                    end else if (dec_phase == phase_q) begin
                        if (dwell_q != DWELL_MAX) begin
                            dwell_d = dwell_q + DWELL_ONE;
                        end
                    end else begin
                        phase_d = dec_phase;
                        dwell_d = DWELL_ONE;
                        if (phase_q == 2'd3) begin
                            cycle_count_d = cycle_count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    phase_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SYNC;
            s_hw_q        <= 3'd0;
            s_fm_q        <= 3'd0;
            smp_vld_q     <= 1'b0;
            phase_q       <= 2'd0;
            phase_valid_q <= 1'b0;
            dwell_q       <= '0;
            cycle_count_q <= 8'd0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
        end else begin
            state_q       <= state_d;
            s_hw_q        <= s_hw_d;
            s_fm_q        <= s_fm_d;
            smp_vld_q     <= smp_vld_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            dwell_q       <= dwell_d;
            cycle_count_q <= cycle_count_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign dwell       = dwell_q;
    assign cycle_count = cycle_count_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_iiitb_tlc_monitor.sv
`timescale 1ns/1ps
// Bench for iiitb_tlc_monitor: three instances (defaults, long minimum dwell, 4-bit
// dwell) share one bus stimulus and are compared against a sample-level reference model.
module tb_iiitb_tlc_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] light_highway = R;
    logic [2:0] light_farm = R;

    always #5 clk = ~clk;

    logic [1:0]  ph_o [3];
    logic        pv_o [3];
    logic [7:0]  cy_o [3];
    logic        fl_o [3];
    logic [2:0]  fc_o [3];
    logic [15:0] dw0, dw1;
    logic [3:0]  dw2;
    logic [15:0] dw_o [3];

    always_comb begin
        dw_o[0] = dw0;
        dw_o[1] = dw1;
        dw_o[2] = {12'd0, dw2};
    end

    iiitb_tlc_monitor u0 (
        .clk(clk), .rst_n(rst_n), .light_highway(light_highway), .light_farm(light_farm),
        .clear(clear), .phase(ph_o[0]), .phase_valid(pv_o[0]), .dwell(dw0),
        .cycle_count(cy_o[0]), .fault(fl_o[0]), .fault_code(fc_o[0]));

    iiitb_tlc_monitor #(.MIN_GREEN(4), .MIN_YELLOW(2)) u1 (
        .clk(clk), .rst_n(rst_n), .light_highway(light_highway), .light_farm(light_farm),
        .clear(clear), .phase(ph_o[1]), .phase_valid(pv_o[1]), .dwell(dw1),
        .cycle_count(cy_o[1]), .fault(fl_o[1]), .fault_code(fc_o[1]));

    iiitb_tlc_monitor #(.CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .light_highway(light_highway), .light_farm(light_farm),
        .clear(clear), .phase(ph_o[2]), .phase_valid(pv_o[2]), .dwell(dw2),
        .cycle_count(cy_o[2]), .fault(fl_o[2]), .fault_code(fc_o[2]));

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: one record per instance, advanced once per captured sample.
    int          mg   [3] = '{1, 4, 1};
    int          my   [3] = '{1, 2, 1};
    int          dmax [3] = '{65535, 65535, 15};
    bit          m_lock [3];
    bit          m_flt  [3];
    logic [1:0]  m_ph   [3];
    logic [15:0] m_dw   [3];
    logic [7:0]  m_cy   [3];
    logic [2:0]  m_fc   [3];
    logic [2:0]  pend_hw, pend_fm;
    bit          pend_vld = 1'b0;

    function automatic logic [2:0] hw_of(input int p);
        case (p)
            0: return G;
            1: return Y;
            default: return R;
        endcase
    endfunction

    function automatic logic [2:0] fm_of(input int p);
        case (p)
            2: return G;
            3: return Y;
            default: return R;
        endcase
    endfunction

    // 0..3 phase, 4 conflict, 5 invalid
    function automatic int classify(input logic [2:0] hw, input logic [2:0] fm);
        for (int p = 0; p < 4; p++)
            if (hw == hw_of(p) && fm == fm_of(p)) return p;
        if (hw != R && fm != R) return 4;
        return 5;
    endfunction

    task automatic mclear(input int k);
        m_lock[k] = 0; m_flt[k] = 0; m_ph[k] = 0; m_dw[k] = 0; m_cy[k] = 0; m_fc[k] = 0;
    endtask

    task automatic mfault(input int k, input logic [2:0] code);
        m_flt[k] = 1;
        m_fc[k]  = code;
    endtask

    task automatic mstep(input int k, input logic [2:0] hw, input logic [2:0] fm);
        int c;
        int need;
        c = classify(hw, fm);
        if (m_flt[k]) return;
        if (!m_lock[k]) begin
            if (c < 4) begin
                m_lock[k] = 1; m_ph[k] = 2'(c); m_dw[k] = 1;
            end else begin
                mfault(k, (c == 4) ? 3'd2 : 3'd1);
            end
            return;
        end
        need = (m_ph[k] == 0 || m_ph[k] == 2) ? mg[k] : my[k];
        if (c == 4) mfault(k, 3'd2);
        else if (c == 5) mfault(k, 3'd1);
        else if (c == int'(m_ph[k])) begin
            if (int'(m_dw[k]) < dmax[k]) m_dw[k] = m_dw[k] + 16'd1;
        end else if (c != (int'(m_ph[k]) + 1) % 4) mfault(k, 3'd3);
        else if (int'(m_dw[k]) < need) mfault(k, 3'd4);
        else begin
            if (m_ph[k] == 3) m_cy[k] = m_cy[k] + 8'd1;
            m_ph[k] = 2'(c);
            m_dw[k] = 1;
        end
    endtask

    // Drive one sample, advance one edge, leave the bench 1ns after the edge.
    task automatic tick(input logic [2:0] hw, input logic [2:0] fm, input logic clr);
        light_highway = hw;
        light_farm    = fm;
        clear         = clr;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (clr) mclear(k);
            else if (pend_vld) mstep(k, pend_hw, pend_fm);
        end
        pend_hw = hw; pend_fm = fm; pend_vld = 1'b1;
        #1;
    endtask

    task automatic tick_ph(input int p);
        tick(hw_of(p), fm_of(p), 1'b0);
    endtask

    task automatic do_reset(input logic [2:0] hw, input logic [2:0] fm);
        light_highway = hw;
        light_farm    = fm;
        clear         = 1'b0;
        rst_n         = 1'b0;
        for (int k = 0; k < 3; k++) mclear(k);
        pend_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(R, Y);
        tests_run++;
        if ({ph_o[0], pv_o[0], dw_o[0], cy_o[0], fl_o[0], fc_o[0]} !== 31'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 0",
                     {ph_o[0], pv_o[0], dw_o[0], cy_o[0], fl_o[0], fc_o[0]});
        end
        tick(R, Y, 1'b0);
        tests_run++;
        if (pv_o[0] !== 1'b0 || fl_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_edge: got pv=%b f=%b want 0 0", pv_o[0], fl_o[0]);
        end
        tick(R, Y, 1'b0);
        tests_run++;
        if (pv_o[0] !== 1'b1 || ph_o[0] !== 2'd3 || dw_o[0] !== 16'd1 || fl_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midseq_lock: got pv=%b ph=%0d dw=%0d f=%b want 1 3 1 0",
                     pv_o[0], ph_o[0], dw_o[0], fl_o[0]);
        end
    endtask

    task automatic test_sequence();
        int seq   [7] = '{0, 0, 0, 1, 2, 3, 0};
        int exp_d [7] = '{1, 2, 3, 1, 1, 1, 1};
        do_reset(G, R);
        for (int i = 0; i < 8; i++) begin
            tick_ph(i < 7 ? seq[i] : 0);
            if (i >= 1) begin
                tests_run++;
                if (ph_o[0] !== 2'(seq[i-1]) || dw_o[0] !== 16'(exp_d[i-1]) || pv_o[0] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL seq_step%0d: got ph=%0d dw=%0d pv=%b want %0d %0d 1",
                             i - 1, ph_o[0], dw_o[0], pv_o[0], seq[i-1], exp_d[i-1]);
                end
            end
        end
        tests_run++;
        if (cy_o[0] !== 8'd1 || fl_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq_cycle: got cy=%0d f=%b want 1 0", cy_o[0], fl_o[0]);
        end
    endtask

    task automatic test_conflict();
        do_reset(G, R);
        for (int i = 0; i < 3; i++) tick_ph(0);
        tick(G, G, 1'b0);
        tick_ph(0);
        tests_run++;
        if (fl_o[0] !== 1'b1 || fc_o[0] !== 3'd2 || ph_o[0] !== 2'd0 || dw_o[0] !== 16'd3 || pv_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict: got f=%b fc=%0d ph=%0d dw=%0d pv=%b want 1 2 0 3 0",
                     fl_o[0], fc_o[0], ph_o[0], dw_o[0], pv_o[0]);
        end
        tick_ph(1);
        tick_ph(2);
        tests_run++;
        if (fl_o[0] !== 1'b1 || fc_o[0] !== 3'd2 || ph_o[0] !== 2'd0 || dw_o[0] !== 16'd3) begin
            tests_failed++;
            $display("FAIL fault_frozen: got f=%b fc=%0d ph=%0d dw=%0d want 1 2 0 3",
                     fl_o[0], fc_o[0], ph_o[0], dw_o[0]);
        end
        tick(G, R, 1'b1);
        tests_run++;
        if (fl_o[0] !== 1'b0 || fc_o[0] !== 3'd0 || pv_o[0] !== 1'b0 || dw_o[0] !== 16'd0 || cy_o[0] !== 8'd0) begin
            tests_failed++;
            $display("FAIL clear: got f=%b fc=%0d pv=%b dw=%0d cy=%0d want all 0",
                     fl_o[0], fc_o[0], pv_o[0], dw_o[0], cy_o[0]);
        end
        tick_ph(0);
        tests_run++;
        if (pv_o[0] !== 1'b1 || dw_o[0] !== 16'd1 || ph_o[0] !== 2'd0) begin
            tests_failed++;
            $display("FAIL resync_after_clear: got pv=%b dw=%0d ph=%0d want 1 1 0",
                     pv_o[0], dw_o[0], ph_o[0]);
        end
    endtask

    task automatic test_illegal();
        do_reset(G, R);
        tick_ph(0); tick_ph(0); tick_ph(2); tick_ph(0);
        tests_run++;
        if (fl_o[0] !== 1'b1 || fc_o[0] !== 3'd3) begin
            tests_failed++;
            $display("FAIL illegal_transition: got f=%b fc=%0d want 1 3", fl_o[0], fc_o[0]);
        end
        do_reset(G, R);
        tick_ph(0); tick(3'b000, R, 1'b0); tick_ph(0);
        tests_run++;
        if (fl_o[0] !== 1'b1 || fc_o[0] !== 3'd1) begin
            tests_failed++;
            $display("FAIL invalid_code: got f=%b fc=%0d want 1 1", fl_o[0], fc_o[0]);
        end
        do_reset(G, R);
        tick_ph(0); tick_ph(0); tick(G, G, 1'b0); tick(G, R, 1'b1); tick_ph(0);
        tests_run++;
        if (fl_o[0] !== 1'b0 || fc_o[0] !== 3'd0 || pv_o[0] !== 1'b1 || dw_o[0] !== 16'd1) begin
            tests_failed++;
            $display("FAIL clear_beats_fault: got f=%b fc=%0d pv=%b dw=%0d want 0 0 1 1",
                     fl_o[0], fc_o[0], pv_o[0], dw_o[0]);
        end
    endtask

    task automatic test_min_dwell();
        do_reset(G, R);
        for (int i = 0; i < 3; i++) tick_ph(0);
        tick_ph(1); tick_ph(1);
        tests_run++;
        if (fl_o[1] !== 1'b1 || fc_o[1] !== 3'd4) begin
            tests_failed++;
            $display("FAIL short_green: got f=%b fc=%0d want 1 4", fl_o[1], fc_o[1]);
        end
        do_reset(G, R);
        for (int i = 0; i < 4; i++) tick_ph(0);
        tick_ph(1); tick_ph(2); tick_ph(2);
        tests_run++;
        if (fl_o[1] !== 1'b1 || fc_o[1] !== 3'd4 || ph_o[1] !== 2'd1) begin
            tests_failed++;
            $display("FAIL short_yellow: got f=%b fc=%0d ph=%0d want 1 4 1", fl_o[1], fc_o[1], ph_o[1]);
        end
        do_reset(G, R);
        for (int i = 0; i < 4; i++) tick_ph(0);
        for (int i = 0; i < 2; i++) tick_ph(1);
        for (int i = 0; i < 4; i++) tick_ph(2);
        for (int i = 0; i < 2; i++) tick_ph(3);
        tick_ph(0); tick_ph(0);
        tests_run++;
        if (fl_o[1] !== 1'b0 || cy_o[1] !== 8'd1 || ph_o[1] !== 2'd0) begin
            tests_failed++;
            $display("FAIL min_dwell_met: got f=%b cy=%0d ph=%0d want 0 1 0", fl_o[1], cy_o[1], ph_o[1]);
        end
    endtask

    task automatic test_saturate();
        do_reset(G, R);
        for (int i = 0; i < 20; i++) tick_ph(0);
        tick_ph(1);
        tests_run++;
        if (dw_o[2] !== 16'd15 || dw_o[0] !== 16'd20) begin
            tests_failed++;
            $display("FAIL dwell_saturate: got dw4=%0d dw16=%0d want 15 20", dw_o[2], dw_o[0]);
        end
        tick_ph(1);
        tests_run++;
        if (ph_o[2] !== 2'd1 || dw_o[2] !== 16'd1 || fl_o[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_saturate: got ph=%0d dw=%0d f=%b want 1 1 0", ph_o[2], dw_o[2], fl_o[2]);
        end
    endtask

    task automatic test_async_reset();
        do_reset(G, R);
        tick_ph(0); tick_ph(1); tick_ph(2); tick_ph(3); tick_ph(0); tick_ph(0); tick_ph(1);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ph_o[0], pv_o[0], dw_o[0], cy_o[0], fl_o[0], fc_o[0]} !== 31'd0 ||
            fl_o[1] !== 1'b0 || fc_o[1] !== 3'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got ph=%0d pv=%b dw=%0d cy=%0d f=%b fc=%0d f1=%b want all 0",
                     ph_o[0], pv_o[0], dw_o[0], cy_o[0], fl_o[0], fc_o[0], fl_o[1]);
        end
        do_reset(G, R);
    endtask

    task automatic test_wrap();
        do_reset(G, R);
        tick_ph(0);
        for (int c = 0; c < 256; c++) begin
            tick_ph(1);
            if (c == 255) begin
                tests_run++;
                if (cy_o[0] !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL cycle_255: got %0d want 255", cy_o[0]);
                end
            end
            tick_ph(2); tick_ph(3); tick_ph(0);
        end
        tick_ph(0);
        tests_run++;
        if (cy_o[0] !== 8'd0 || fl_o[0] !== 1'b0 || pv_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL cycle_wrap: got cy=%0d f=%b pv=%b want 0 0 1", cy_o[0], fl_o[0], pv_o[0]);
        end
    endtask

    task automatic test_random();
        int cur;
        int left;
        int r;
        logic [2:0] hw, fm;
        logic clr;
        cur  = $urandom_range(0, 3);
        left = 3;
        do_reset(hw_of(cur), fm_of(cur));
        for (int n = 0; n < 3000; n++) begin
            if (left == 0) begin
                cur  = (cur + 1) % 4;
                left = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(1, 5);
            end
            left--;
            r  = $urandom_range(0, 199);
            hw = hw_of(cur);
            fm = fm_of(cur);
            if (r < 3) begin
                hw = 3'($urandom_range(0, 7));
                fm = 3'($urandom_range(0, 7));
            end else if (r < 5) begin
                cur = $urandom_range(0, 3);
                hw  = hw_of(cur);
                fm  = fm_of(cur);
            end
            clr = (r >= 196) || (m_flt[0] && m_flt[1] && m_flt[2] && r < 60);
            tick(hw, fm, clr);
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if ({ph_o[k], pv_o[k], dw_o[k], cy_o[k], fl_o[k], fc_o[k]} !==
                    {m_ph[k], m_lock[k] & ~m_flt[k], m_dw[k], m_cy[k], m_flt[k], m_fc[k]}) begin
                    tests_failed++;
                    $display("FAIL rand dut%0d step%0d: got ph=%0d pv=%b dw=%0d cy=%0d f=%b fc=%0d want ph=%0d pv=%b dw=%0d cy=%0d f=%b fc=%0d",
                             k, n, ph_o[k], pv_o[k], dw_o[k], cy_o[k], fl_o[k], fc_o[k],
                             m_ph[k], m_lock[k] & ~m_flt[k], m_dw[k], m_cy[k], m_flt[k], m_fc[k]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        test_reset();
        test_sequence();
        test_conflict();
        test_illegal();
        test_min_dwell();
        test_saturate();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/iiitb_tlc_monitor.md
# iiitb_tlc_monitor

Passive checker on the light-output side of the traffic-light controller. It samples the highway and farm light buses and decodes them back into controller phases. It enforces the legal phase sequence and minimum dwell times, and reports the current phase, dwell length, completed cycles and a sticky fault with cause code. It sits beside the controller in the top level and in the bench, and drives nothing back into the controller.

## Interface
- MIN_GREEN, 1, minimum sampled cycles required in a green phase (HGRE_FRED, HRED_FGRE) before leaving it
- MIN_YELLOW, 1, minimum sampled cycles required in a yellow phase (HYEL_FRED, HRED_FYEL) before leaving it
- CNT_W, 16, width of the dwell counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- light_highway  in  3  highway lamp code: 001 green, 010 yellow, 100 red
- light_farm  in  3  farm lamp code, same encoding
- clear  in  1  synchronous clear of fault and statistics
- phase  out  2  decoded phase: 00 HGRE_FRED, 01 HYEL_FRED, 10 HRED_FGRE, 11 HRED_FYEL
- phase_valid  out  1  monitor is locked and tracking
- dwell  out  CNT_W  consecutive sampled cycles in the current phase, saturating
- cycle_count  out  8  completed full cycles, wrapping
- fault  out  1  sticky fault flag
- fault_code  out  3  0 none, 1 invalid encoding, 2 conflict, 3 illegal transition, 4 short dwell

## Operation
- Input stage: both buses are registered every clk into s_hw/s_fm. All decoding uses the registered values.
- Decode: the pairs (001,100), (010,100), (100,001), (100,010) map to phases 00..11.
  - Conflict: neither side is 100.
  - Invalid: any other pair that is not conflict, including non-one-hot codes and 100/100.
- FSM states: SYNC, TRACK, FAULT.
- SYNC (state after reset or clear): phase_valid=0. On the first valid decode, go to TRACK with phase=decoded and dwell=1. Conflict or invalid in SYNC also goes to FAULT.
- TRACK, same phase: dwell increments, saturating at 2^CNT_W-1.
- TRACK, phase changes to the successor ((phase+1) mod 4) with dwell ≥ the minimum for the old phase: legal.
  - Load the new phase and set dwell=1.
  - If the transition is 11→00, increment cycle_count (255 wraps to 0).
- TRACK, any other event: go to FAULT with fault=1. Code priority: conflict(2) > invalid(1) > illegal transition(3, non-successor phase) > short dwell(4).
- FAULT:
  - fault, fault_code, phase and dwell are frozen.
  - phase_valid=0 and cycle_count is held.
  - Exit only by clear or reset.
- clear (any state):
  - Next edge: state=SYNC, fault=0, fault_code=0, dwell=0, cycle_count=0, phase=00, phase_valid=0.
  - clear has priority over every event in the same cycle.
- Parameter rule: MIN_GREEN and MIN_YELLOW ≥ 1. The defaults accept the controller's native one-cycle yellow and minimum green.

## Timing
- Reset: all outputs are 0, state=SYNC, and s_hw/s_fm are 0. Reset takes effect immediately, mid-phase or mid-fault.
- Latency: a pattern present at edge N (captured into s_*) is reflected on phase/dwell/fault at edge N+1. The total lag is two edges from the bus change.
- Fault assertion happens in the same cycle as the phase update would have, i.e. edge N+1 after the offending sample.
- A legal transition and a dwell saturation never occur together, because dwell resets to 1 on the transition.
- Releasing rst_n while the buses show a mid-sequence phase: the monitor locks on that phase. This is not a fault.
- clear asserted while a fault-causing sample is pending: clear wins, the fault is not recorded, and the monitor resyncs on the next valid sample.

## Test plan
- Defaults, buses GR,GR,GR,YR,RG,RY,GR after reset:
  - phase reads 00,00,00,01,10,11,00 with two-edge lag.
  - dwell reads 1,2,3,1,1,1,1.
  - cycle_count=1, fault=0.
- Buses hw=001, fm=001 while in TRACK: fault=1 and fault_code=2 one edge after capture. A following legal pattern changes nothing until clear pulses; after clear, phase_valid rises on the next valid sample.
- GR then RG directly: fault_code=3. Buses hw=000, fm=100: fault_code=1.
- MIN_GREEN=4, MIN_YELLOW=2, one sequence run with the green phase and then the yellow phase held too short:
  - GR×3 then YR: fault_code=4.
  - Rerun with GR×4 then YR×1 then RG: fault_code=4 on the yellow exit.
  - Rerun with GR×4, YR×2, RG×4, RY×2, GR: no fault, cycle_count=1.
- CNT_W=4, GR held 20 cycles: dwell saturates at 15. The following YR is accepted with dwell=1.
- Async reset:
  - rst_n low mid-TRACK: all outputs are 0 immediately.
  - 256 full legal cycles: cycle_count wraps to 0.
